burst_mem_responder: RTL and testbench
======================================

Name: burst_mem_responder

Overview:
Synthesizable physical-memory responder on the memory side of the 64-bit burst pmem interface that the cacheline adaptor drives.
- Accepts line reads and line writes, applies a fixed access latency, then streams or absorbs BEATS consecutive 64-bit beats, each qualified by pmem_resp.
- Used as on-chip backing RAM for FPGA bring-up and as a synthesizable memory for system-level simulation.

Parameters:
s_offset, 5, log2 of line size in bytes; BEATS = 2^s_offset*8/64 (4 by default)
mem_s_index, 10, log2 of number of stored lines
LATENCY, 4, idle cycles between request acceptance and the first beat; 0 is legal

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
pmem_read  input  1  line read request, held by initiator until burst completes
pmem_write  input  1  line write request, held by initiator until burst completes
pmem_address  input  32  byte address; offset bits [s_offset-1:0] ignored
pmem_wdata  input  64  write beat, valid in cycles where pmem_resp=1 during a write
pmem_resp  output  1  beat strobe
pmem_rdata  output  64  read beat, valid when pmem_resp=1 during a read
protocol_err  output  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high on rst.
- On reset: state IDLE; pmem_resp=0, pmem_rdata=0, protocol_err=0; beat counter and latency counter = 0. Memory contents are not cleared.
- All outputs are registered.
- Line index = pmem_address[s_offset+mem_s_index-1:s_offset]. Upper address bits are ignored, so the memory aliases.
- States: IDLE, WAIT, RBURST, WBURST, DONE.
- IDLE:
  - If pmem_read or pmem_write is sampled high in cycle N, latch the index and the op, and clear the beat counter.
  - If both are high, read wins.
  - Next state is WAIT, or RBURST/WBURST directly when LATENCY=0.
- WAIT: count LATENCY cycles, then go to the latched burst state. The first pmem_resp is asserted in cycle N+LATENCY+1.
- RBURST:
  - pmem_resp=1 for BEATS consecutive cycles.
  - Beat k drives line bits [64k+63:64k], k ascending from 0.
  - After beat BEATS-1, go to DONE.
- WBURST:
  - pmem_resp=1 for BEATS consecutive cycles.
  - At the clock edge ending resp cycle k, pmem_wdata is written into beat k of the latched line.
  - After beat BEATS-1, go to DONE.
- DONE:
  - One cycle with pmem_resp=0 and request inputs ignored, so the initiator can deassert its request.
  - Then return to IDLE.
  - Minimum spacing between bursts: LATENCY+BEATS+2 cycles.
- pmem_rdata holds its last value when pmem_resp=0 (no X).
- A read of a line sees all write bursts to that line that completed earlier.
- The op and index are latched; changes to pmem_address or pmem_read/pmem_write after acceptance do not affect the burst in flight.
- Reset mid-burst: return to IDLE and drive pmem_resp=0 in the next cycle. Beats of an interrupted write that were already committed stay written; the remaining beats are unchanged.
- Deasserting the request mid-burst is not legal; the responder completes the burst anyway.

Optional Feature:
Macro BURST_MEM_PROTOCOL_CHECK_EN.
- Defined: protocol_err sets and stays set until rst on any of:
  - pmem_read and pmem_write both high in the same cycle;
  - the accepted request deasserted, or the opposite request asserted, during WAIT, RBURST or WBURST;
  - pmem_address line index changed from the latched index before DONE.
  Also emits a simulation $error naming the violation.
- Not defined: protocol_err is tied to 0 and no checker logic is generated.
- Burst behaviour is identical in both cases.

Decomposition:
- Package burst_mem_types:
  - BEAT_W=64 constant;
  - function computing BEATS from s_offset;
  - state enum bm_state_t {IDLE, WAIT, RBURST, WBURST, DONE}.
- Sub-module burst_mem_array: synchronous beat-granular 1R1W RAM, addressed by {line index, beat}, with a registered read.
- The FSM pre-issues the read address one cycle ahead so that pmem_rdata stays registered.

Test Plan:
- Write line 0x40 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 (LATENCY=4, request in cycle 0) -> pmem_resp high in cycles 5-8, low in cycle 9.
- Read 0x5C (same line, offset ignored) -> pmem_rdata = 0x11..11, 0x22..22, 0x33..33, 0x44..44 in resp cycles 5-8.
- LATENCY=0: read request in cycle 0 -> first pmem_resp in cycle 1; four beats; pmem_resp=0 in cycle 5.
- Back-to-back: write 0x80 held, then read 0x80 asserted in the DONE cycle -> read ignored until IDLE, then accepted; returns the newly written data.
- rst in the 2nd write beat -> pmem_resp=0 next cycle; subsequent read returns new beats 0-1 and old beats 2-3.
- With BURST_MEM_PROTOCOL_CHECK_EN: read and write both high -> read served and protocol_err=1 until rst. Without the macro -> protocol_err stays 0.

Source files
------------

// File: rtl/burst_mem_types.sv
// ---------------------------------------------------------------------------
// burst_mem_types
// Shared definitions for the burst memory responder slice.
//   BEAT_W            : width of one pmem beat in bits
//   beats_from_offset : number of beats per line for a given log2 line size
//   bm_state_t        : responder FSM states
// ---------------------------------------------------------------------------
package burst_mem_types;

    localparam int unsigned BEAT_W = 64;

    // Line size is 2^offset bytes; a line is carried as BEAT_W-bit beats.
    function automatic int unsigned beats_from_offset(input int unsigned offset);
        return ((32'd1 << offset) * 32'd8) / BEAT_W;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST,
        DONE
    } bm_state_t;

endpackage

// File: rtl/burst_mem_array.sv
// ---------------------------------------------------------------------------
// burst_mem_array
// Beat-granular 1R1W synchronous RAM with a registered read port.
//   clk       : clock
//   rst       : synchronous active-high reset (clears only the read register)
//   rd_en_i   : load rd_data_o from rd_addr_i at the next edge
//   rd_addr_i : read address {line index, beat}
//   rd_data_o : registered read data, holds its value while rd_en_i is low
//   wr_en_i   : write wr_data_i to wr_addr_i at the next edge
//   wr_addr_i : write address {line index, beat}
//   wr_data_i : write data
// ---------------------------------------------------------------------------
module burst_mem_array
    import burst_mem_types::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [BEAT_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [BEAT_W-1:0] wr_data_i
);

    logic [BEAT_W-1:0] mem [2**AW];
    logic [BEAT_W-1:0] rdData_q;

    // Storage is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // The output register doubles as the responder's pmem_rdata register:
    // it resets to zero and holds between reads so the bus never shows X.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_q <= '0;
        end else if (rd_en_i) begin
            rdData_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/burst_mem_responder.sv
// ---------------------------------------------------------------------------
// burst_mem_responder
// Memory-side responder for the 64-bit burst pmem interface. Accepts a line
// read or write, waits LATENCY cycles, then streams/absorbs BEATS beats, each
// strobed by pmem_resp, followed by one DONE cycle.
//   clk, rst     : clock, synchronous active-high reset
//   pmem_read    : line read request (held until the burst completes)
//   pmem_write   : line write request (held until the burst completes)
//   pmem_address : byte address, offset bits ignored, upper bits alias
//   pmem_wdata   : write beat, sampled in pmem_resp cycles of a write
//   pmem_resp    : beat strobe
//   pmem_rdata   : read beat, valid with pmem_resp during a read
//   protocol_err : sticky protocol-violation flag
// Optional feature macro: BURST_MEM_PROTOCOL_CHECK_EN enables the protocol
// checker; without it protocol_err is tied low.
// ---------------------------------------------------------------------------
module burst_mem_responder
    import burst_mem_types::*;
#(
    parameter int unsigned s_offset    = 5,
    parameter int unsigned mem_s_index = 10,
    parameter int unsigned LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [BEAT_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [BEAT_W-1:0] pmem_rdata,
    output logic              protocol_err
);

    localparam int unsigned BEATS = beats_from_offset(s_offset);
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IW    = mem_s_index;
    localparam int unsigned LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned AW    = IW + BW;

    bm_state_t         state_q,   state_d;
    logic [BW-1:0]     beatCnt_q, beatCnt_d;
    logic [LW-1:0]     latCnt_q,  latCnt_d;
    logic [IW-1:0]     lineIdx_q, lineIdx_d;
    logic              opRead_q,  opRead_d;
    logic              resp_q,    resp_d;

    logic [IW-1:0]     addrIdx;
    logic              rdEn;
    logic [AW-1:0]     rdAddr;
    logic              wrEn;
    logic [AW-1:0]     wrAddr;
    logic              addrBits_unused;

    assign addrIdx         = pmem_address[s_offset +: IW];
    assign addrBits_unused = ^{pmem_address[31:s_offset+IW], pmem_address[s_offset-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
            latCnt_q  <= '0;
            lineIdx_q <= '0;
            opRead_q  <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beatCnt_q <= beatCnt_d;
            latCnt_q  <= latCnt_d;
            lineIdx_q <= lineIdx_d;
            opRead_q  <= opRead_d;
            resp_q    <= resp_d;
        end
    end

    // Next-state logic. pmem_resp is registered, so it is derived from the
    // state we are about to enter rather than the current one.
    always_comb begin
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        latCnt_d  = latCnt_q;
        lineIdx_d = lineIdx_q;
        opRead_d  = opRead_q;

        unique case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    lineIdx_d = addrIdx;
                    opRead_d  = pmem_read;
                    beatCnt_d = '0;
                    latCnt_d  = '0;
                    if (LATENCY == 0) begin
                        state_d = pmem_read ? RBURST : WBURST;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (latCnt_q == LW'(LATENCY - 1)) begin
                    state_d = opRead_q ? RBURST : WBURST;
                end else begin
                    latCnt_d = latCnt_q + 1'b1;
                end
            end
            RBURST, WBURST: begin
                if (beatCnt_q == BW'(BEATS - 1)) begin
                    state_d = DONE;
                end else begin
                    beatCnt_d = beatCnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        resp_d = (state_d == RBURST) || (state_d == WBURST);
    end

    // Read address is issued one cycle ahead from the next-state values so
    // the RAM's output register lines up with the pmem_resp cycle.
    // Writes commit on the edge ending each WBURST cycle, even if rst is
    // high in that cycle, so beats already strobed stay written.
    always_comb begin
        rdEn   = (state_d == RBURST);
        rdAddr = {lineIdx_d, beatCnt_d};
        wrEn   = (state_q == WBURST);
        wrAddr = {lineIdx_q, beatCnt_q};
    end

    burst_mem_array #(
        .AW(AW)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_en_i   (rdEn),
        .rd_addr_i (rdAddr),
        .rd_data_o (pmem_rdata),
        .wr_en_i   (wrEn),
        .wr_addr_i (wrAddr),
        .wr_data_i (pmem_wdata)
    );

    assign pmem_resp = resp_q;

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
    logic err_q, err_d;
    logic bothHigh, inFlight, reqBroken, idxChanged;

    // A burst is in flight from acceptance until DONE; during that window
    // the accepted request must stay asserted, alone, on the same line.
    always_comb begin
        bothHigh   = pmem_read && pmem_write;
        inFlight   = (state_q == WAIT) || (state_q == RBURST) || (state_q == WBURST);
        reqBroken  = inFlight && (opRead_q ? (!pmem_read || pmem_write)
                                           : (!pmem_write || pmem_read));
        idxChanged = inFlight && (addrIdx != lineIdx_q);
        err_d      = err_q || bothHigh || reqBroken || idxChanged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (bothHigh) begin
                $error("burst_mem_responder: pmem_read and pmem_write both high");
            end
            if (reqBroken) begin
                $error("burst_mem_responder: request changed during burst");
            end
            if (idxChanged) begin
                $error("burst_mem_responder: line index changed during burst");
            end
        end
    end

    assign protocol_err = err_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_burst_mem_responder
// Drives two responders (LATENCY=4 and LATENCY=0) with directed and random
// line bursts and compares every cycle's pmem_resp and every read beat with
// a line-store model indexed by {dut, line, beat}.
// ---------------------------------------------------------------------------
module tb_burst_mem_responder;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdA, wrA, rdB, wrB;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        respA, respB, errA, errB;
    logic [63:0] rdataA, rdataB;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] refMem  [int];
    bit          written [int];

    always #5 clk = ~clk;

    burst_mem_responder #(.s_offset(5), .mem_s_index(10), .LATENCY(4)) dutA (
        .clk(clk), .rst(rst), .pmem_read(rdA), .pmem_write(wrA),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_resp(respA),
        .pmem_rdata(rdataA), .protocol_err(errA)
    );

    burst_mem_responder #(.s_offset(5), .mem_s_index(10), .LATENCY(0)) dutB (
        .clk(clk), .rst(rst), .pmem_read(rdB), .pmem_write(wrB),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_resp(respB),
        .pmem_rdata(rdataB), .protocol_err(errB)
    );

    // Single comparison point: counts every comparison and reports misses.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic obsResp(input int sel);
        return (sel == 0) ? respA : respB;
    endfunction

    function automatic logic [63:0] obsRdata(input int sel);
        return (sel == 0) ? rdataA : rdataB;
    endfunction

    task automatic setReq(input int sel, input bit r, input bit w);
        if (sel == 0) begin
            rdA = r;
            wrA = w;
        end else begin
            rdB = r;
            wrB = w;
        end
    endtask

    function automatic int lineKey(input int sel, input logic [31:0] a);
        return sel * 4096 + int'(a[14:5]) * BEATS;
    endfunction

    // One full burst starting at the current (IDLE) cycle 0. The expected
    // strobe pattern is resp high in cycles LAT+1..LAT+4 and low otherwise;
    // the request is dropped (or turned into a read) in the DONE cycle.
    // rstCycle >= 0 pulses rst in that cycle and ends the burst there.
    task automatic applyStimulus(input string tag, input int sel, input bit isRead,
                                 input logic [31:0] a, input logic [255:0] wline,
                                 input bit chainRead, input int rstCycle,
                                 input bit bothHigh);
        int  lat;
        int  beatIdx;
        bit  expResp;
        bit  didReset;
        lat      = (sel == 0) ? 4 : 0;
        didReset = 1'b0;
        addr     = a;
        setReq(sel, isRead, !isRead || bothHigh);
        for (int cyc = 0; cyc <= lat + 5; cyc++) begin
            beatIdx = cyc - (lat + 1);
            expResp = (beatIdx >= 0) && (beatIdx < BEATS);
            if (!isRead && expResp) begin
                wdata = wline[beatIdx*64 +: 64];
            end else begin
                wdata = {$urandom(), $urandom()};
            end
            if (cyc == lat + 5) begin
                setReq(sel, chainRead, 1'b0);
            end
            if (cyc == rstCycle) begin
                rst = 1'b1;
            end
            @(negedge clk);
            checkOutput($sformatf("%s resp c%0d", tag, cyc), {63'd0, obsResp(sel)}, {63'd0, expResp});
            if (expResp) begin
                if (isRead) begin
                    checkOutput($sformatf("%s beat%0d", tag, beatIdx), obsRdata(sel),
                                refMem[lineKey(sel, a) + beatIdx]);
                end else begin
                    refMem[lineKey(sel, a) + beatIdx] = wline[beatIdx*64 +: 64];
                end
            end
            @(posedge clk);
            #1;
            if (cyc == rstCycle) begin
                didReset = 1'b1;
                break;
            end
        end
        if (didReset) begin
            rst = 1'b0;
            setReq(sel, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("%s resp after rst", tag), {63'd0, obsResp(sel)}, 64'd0);
            checkOutput($sformatf("%s rdata after rst", tag), obsRdata(sel), 64'd0);
            @(posedge clk);
            #1;
        end else if (!isRead) begin
            written[lineKey(sel, a)] = 1'b1;
        end
    endtask

    function automatic logic [255:0] randLine();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [255:0] lineA;
        logic [255:0] lineB;
        logic [31:0]  ra;
        int           sel;
        int           idx;

        rst = 1'b1;
        rdA = 1'b0; wrA = 1'b0; rdB = 1'b0; wrB = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset respA", {63'd0, respA}, 64'd0);
        checkOutput("reset rdataA", rdataA, 64'd0);
        checkOutput("reset errA", {63'd0, errA}, 64'd0);
        checkOutput("reset respB", {63'd0, respB}, 64'd0);
        checkOutput("reset rdataB", rdataB, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed: write 0x40, read 0x5C");
        lineA = {64'h4444444444444444, 64'h3333333333333333,
                 64'h2222222222222222, 64'h1111111111111111};
        applyStimulus("wr40", 0, 1'b0, 32'h40, lineA, 1'b0, -1, 1'b0);
        applyStimulus("rd5C", 0, 1'b1, 32'h5C, '0, 1'b0, -1, 1'b0);

        $display("[TB] directed: LATENCY=0 responder");
        applyStimulus("B wr40", 1, 1'b0, 32'h40, randLine(), 1'b0, -1, 1'b0);
        applyStimulus("B rd40", 1, 1'b1, 32'h40, '0, 1'b0, -1, 1'b0);

        $display("[TB] directed: write then read chained in DONE");
        applyStimulus("wr80", 0, 1'b0, 32'h80, randLine(), 1'b1, -1, 1'b0);
        applyStimulus("rd80", 0, 1'b1, 32'h80, '0, 1'b0, -1, 1'b0);

        $display("[TB] directed: reset during second write beat");
        lineB = randLine();
        applyStimulus("wrC0 full", 0, 1'b0, 32'hC0, lineB, 1'b0, -1, 1'b0);
        applyStimulus("wrC0 cut", 0, 1'b0, 32'hC0, randLine(), 1'b0, 6, 1'b0);
        applyStimulus("rdC0", 0, 1'b1, 32'hC0, '0, 1'b0, -1, 1'b0);

        $display("[TB] directed: read and write both high");
        applyStimulus("both40", 0, 1'b1, 32'h40, '0, 1'b0, -1, 1'b1);
        @(negedge clk);
`ifdef BURST_MEM_PROTOCOL_CHECK_EN
        checkOutput("both errA", {63'd0, errA}, 64'd1);
`else
        checkOutput("both errA", {63'd0, errA}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("errA after rst", {63'd0, errA}, 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] random bursts with aliased addresses");
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 7));
            ra  = ($urandom() & ~32'h00007FE0) | (32'(idx) << 5);
            if (!written.exists(lineKey(sel, ra)) || ($urandom_range(0, 1) == 0)) begin
                applyStimulus($sformatf("rnd%0d wr", n), sel, 1'b0, ra, randLine(), 1'b0, -1, 1'b0);
            end else begin
                applyStimulus($sformatf("rnd%0d rd", n), sel, 1'b1, ra, '0, 1'b0, -1, 1'b0);
            end
        end
        @(negedge clk);
        checkOutput("final errA", {63'd0, errA}, 64'd0);
        checkOutput("final errB", {63'd0, errB}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
